// File: rtl/pobieranie_rozkazu_if.sv
// Fetch-stage bundle: control from execute, the program ROM port, and the
// instruction register view that decode/execute consume.
interface pobieranie_rozkazu_if #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int STACK_DEPTH = 4
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    // Handshake: there is no back-pressure on the output. instr is meaningful
    // only while instr_vld=1, and a redirect takes effect on the edge it is
    // sampled at. stall holds the whole stage but never masks a redirect.
    logic                  stall;
    logic                  jump_en;
    logic                  call_en;
    logic                  ret_en;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  instr_vld;
    logic [DEPTH_W-1:0]    stk_depth;
    logic                  stk_err;

    modport master (
        output stall, jump_en, call_en, ret_en, target, rom_data,
        input  rom_addr, instr, instr_pc, instr_vld, stk_depth, stk_err
    );

    modport slave (
        input  stall, jump_en, call_en, ret_en, target, rom_data,
        output rom_addr, instr, instr_pc, instr_vld, stk_depth, stk_err
    );
endinterface

// File: rtl/pobieranie_rozkazu.sv
// Instruction fetch: PC, registered instruction, jump/call/return redirects
// and a small LIFO return-address stack with a sticky error flag.
module pobieranie_rozkazu #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int RESET_PC    = 0,
    parameter int STACK_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    pobieranie_rozkazu_if.slave    bus
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int PTR_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [ADDR_WIDTH-1:0] PC_RST = ADDR_WIDTH'(RESET_PC);
    localparam logic [DEPTH_W-1:0]    DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic                  instr_vld_q, instr_vld_d;
    logic [DEPTH_W-1:0]    depth_q, depth_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] stk_q [STACK_DEPTH];
    logic [ADDR_WIDTH-1:0] stk_d [STACK_DEPTH];

    logic                  do_jump, do_call, try_ret, do_ret;
    logic                  stk_empty, stk_full;
    logic [PTR_W-1:0]      push_idx, pop_idx;
    logic [ADDR_WIDTH-1:0] pop_val;

    assign stk_empty = (depth_q == '0);
    assign stk_full  = (depth_q == DEPTH_FULL);
    assign push_idx  = PTR_W'(depth_q);
    assign pop_idx   = PTR_W'(depth_q - DEPTH_W'(1));
    assign pop_val   = stk_q[pop_idx];

    // Fixed priority jump > call > ret; a ret on an empty stack is not a redirect.
    assign do_jump = bus.jump_en;
    assign do_call = !bus.jump_en && bus.call_en;
    assign try_ret = !bus.jump_en && !bus.call_en && bus.ret_en;
    assign do_ret  = try_ret && !stk_empty;

    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        instr_vld_d = instr_vld_q;
        depth_d     = depth_q;
        err_d       = err_q;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            stk_d[i] = stk_q[i];
        end

        if (do_jump) begin
            pc_d        = bus.target;
            instr_vld_d = 1'b0;
        end else if (do_call) begin
            pc_d        = bus.target;
            instr_vld_d = 1'b0;
            if (stk_full) begin
                err_d = 1'b1;
            end else begin
                stk_d[push_idx] = instr_pc_q + ADDR_WIDTH'(1);
                depth_d         = depth_q + DEPTH_W'(1);
            end
        end else if (do_ret) begin
            pc_d        = pop_val;
            instr_vld_d = 1'b0;
            depth_d     = depth_q - DEPTH_W'(1);
        end else begin
            // Underflowing ret falls through to an ordinary fetch or stall.
            if (try_ret) begin
                err_d = 1'b1;
            end
            if (!bus.stall) begin
                instr_d     = bus.rom_data;
                instr_pc_d  = pc_q;
                instr_vld_d = 1'b1;
                pc_d        = pc_q + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= PC_RST;
            instr_q     <= '0;
            instr_pc_q  <= '0;
            instr_vld_q <= 1'b0;
            depth_q     <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stk_q[i] <= '0;
            end
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            instr_vld_q <= instr_vld_d;
            depth_q     <= depth_d;
            err_q       <= err_d;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stk_q[i] <= stk_d[i];
            end
        end
    end

    assign bus.rom_addr  = pc_q;
    assign bus.instr     = instr_q;
    assign bus.instr_pc  = instr_pc_q;
    assign bus.instr_vld = instr_vld_q;
    assign bus.stk_depth = depth_q;
    assign bus.stk_err   = err_q;
endmodule

// File: tb/tb_pobieranie_rozkazu.sv
// Directed bench for the fetch stage; the ROM returns address + 0x100.
module tb_pobieranie_rozkazu;
  logic clk;
  logic rst;
  int   vec_cnt;
  int   err_cnt;

  pobieranie_rozkazu_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .STACK_DEPTH(4)) bus ();

  pobieranie_rozkazu #(
    .ADDR_WIDTH(8), .DATA_WIDTH(16), .RESET_PC(0), .STACK_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  assign bus.rom_data = 16'h0100 + {8'h00, bus.rom_addr};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] pc, input logic [15:0] ins,
                           input logic [7:0] ipc, input logic vld, input logic [2:0] dep,
                           input logic err);
    check({tag, ".pc"},    32'(bus.rom_addr),  32'(pc));
    check({tag, ".instr"}, 32'(bus.instr),     32'(ins));
    check({tag, ".ipc"},   32'(bus.instr_pc),  32'(ipc));
    check({tag, ".vld"},   32'(bus.instr_vld), 32'(vld));
    check({tag, ".depth"}, 32'(bus.stk_depth), 32'(dep));
    check({tag, ".err"},   32'(bus.stk_err),   32'(err));
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.jump_en = 1'b0;
    bus.call_en = 1'b0;
    bus.ret_en  = 1'b0;
    bus.stall   = 1'b0;
  endtask

  logic [7:0] call_tgt [5] = '{8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
  logic [7:0] call_ipc [5] = '{8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
  logic [7:0] ret_pc   [4] = '{8'h41, 8'h31, 8'h21, 8'h12};

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst = 1'b1;
    bus.target = 8'h00;
    idle();
    step();
    check_all("reset", 8'h00, 16'h0000, 8'h00, 1'b0, 3'd0, 1'b0);
    rst = 1'b0;

    // 1: first fetches
    step();
    check_all("t1a", 8'h01, 16'h0100, 8'h00, 1'b1, 3'd0, 1'b0);
    step();
    check_all("t1b", 8'h02, 16'h0101, 8'h01, 1'b1, 3'd0, 1'b0);

    // 2: stall at pc=5
    step(); step(); step();
    check_all("t2pre", 8'h05, 16'h0104, 8'h04, 1'b1, 3'd0, 1'b0);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("t2stall", 8'h05, 16'h0104, 8'h04, 1'b1, 3'd0, 1'b0);
    end
    bus.stall = 1'b0;
    step();
    check_all("t2rel", 8'h06, 16'h0105, 8'h05, 1'b1, 3'd0, 1'b0);

    // 3: jump overrides stall
    bus.stall = 1'b1; bus.jump_en = 1'b1; bus.target = 8'h40;
    step();
    check_all("t3jmp", 8'h40, 16'h0105, 8'h05, 1'b0, 3'd0, 1'b0);
    idle();
    step();
    check_all("t3tgt", 8'h41, 16'h0140, 8'h40, 1'b1, 3'd0, 1'b0);

    // 4: call from instr_pc=0x10, then return
    bus.jump_en = 1'b1; bus.target = 8'h10;
    step();
    idle();
    step();
    check_all("t4at10", 8'h11, 16'h0110, 8'h10, 1'b1, 3'd0, 1'b0);
    bus.call_en = 1'b1; bus.target = 8'h80;
    step();
    check_all("t4call", 8'h80, 16'h0110, 8'h10, 1'b0, 3'd1, 1'b0);
    idle();
    step();
    check_all("t4sub0", 8'h81, 16'h0180, 8'h80, 1'b1, 3'd1, 1'b0);
    step();
    bus.ret_en = 1'b1;
    step();
    check_all("t4ret", 8'h11, 16'h0181, 8'h81, 1'b0, 3'd0, 1'b0);
    idle();
    step();
    check_all("t4back", 8'h12, 16'h0111, 8'h11, 1'b1, 3'd0, 1'b0);

    // 5: nest five calls into a four-deep stack
    for (int i = 0; i < 5; i++) begin
      bus.call_en = 1'b1; bus.target = call_tgt[i];
      step();
      check("t5call.pc", 32'(bus.rom_addr), 32'(call_tgt[i]));
      check("t5call.depth", 32'(bus.stk_depth), (i < 4) ? (i + 1) : 4);
      check("t5call.err", 32'(bus.stk_err), (i < 4) ? 0 : 1);
      idle();
      step();
      check("t5run.ipc", 32'(bus.instr_pc), 32'(call_ipc[i]));
    end
    for (int i = 0; i < 4; i++) begin
      bus.ret_en = 1'b1;
      step();
      check("t5ret.pc", 32'(bus.rom_addr), 32'(ret_pc[i]));
      check("t5ret.vld", 32'(bus.instr_vld), 0);
      check("t5ret.depth", 32'(bus.stk_depth), 3 - i);
      idle();
      step();
      check("t5run2.instr", 32'(bus.instr), 32'h100 + 32'(ret_pc[i]));
    end
    bus.ret_en = 1'b1;
    step();
    check_all("t5under", 8'h14, 16'h0113, 8'h13, 1'b1, 3'd0, 1'b1);

    // 6: jump beats call with no push, then PC wrap
    bus.ret_en = 1'b0; bus.jump_en = 1'b1; bus.call_en = 1'b1; bus.target = 8'hFE;
    step();
    check_all("t6prio", 8'hFE, 16'h0113, 8'h13, 1'b0, 3'd0, 1'b1);
    idle();
    step();
    check_all("t6fe", 8'hFF, 16'h01FE, 8'hFE, 1'b1, 3'd0, 1'b1);
    step();
    check_all("t6ff", 8'h00, 16'h01FF, 8'hFF, 1'b1, 3'd0, 1'b1);
    step();
    check_all("t6wrap", 8'h01, 16'h0100, 8'h00, 1'b1, 3'd0, 1'b1);

    // reset in the middle of a call sequence
    bus.call_en = 1'b1; bus.target = 8'h33;
    step();
    check_all("t6call", 8'h33, 16'h0100, 8'h00, 1'b0, 3'd1, 1'b1);
    rst = 1'b1; bus.target = 8'h77;
    step();
    check_all("t6rst", 8'h00, 16'h0000, 8'h00, 1'b0, 3'd0, 1'b0);
    rst = 1'b0;
    idle();
    step();
    check_all("t6post", 8'h01, 16'h0100, 8'h00, 1'b1, 3'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
